// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a raster-ordered signed feature map.
// Define MAXPOOL_REQUANT_EN to requantize results (>>> SHIFT, clamp to SAT_WIDTH unsigned bits).
module maxpool2x2_stream #(
  parameter int IN_W      = 24,
  parameter int IN_H      = 24,
  parameter int IN_WIDTH  = 32,
  parameter int SHIFT     = 8,
  parameter int SAT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [IN_WIDTH-1:0] data_in,
  output logic [IN_WIDTH-1:0] data_out,
  output logic                valid_out,
  output logic                frame_done
);

  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(IN_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);
  localparam logic [CW-1:0] COL_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] ROW_ONE  = {{(RW-1){1'b0}}, 1'b1};
  localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
    {{(IN_WIDTH-SAT_WIDTH){1'b0}}, {SAT_WIDTH{1'b1}}};

  function automatic logic signed [IN_WIDTH-1:0] smax(
    input logic signed [IN_WIDTH-1:0] a,
    input logic signed [IN_WIDTH-1:0] b
  );
    smax = (a > b) ? a : b;
  endfunction

  function automatic logic [IN_WIDTH-1:0] requant(input logic signed [IN_WIDTH-1:0] m);
    logic signed [IN_WIDTH-1:0] s;
    s = m >>> SHIFT;
    if (s < $signed({IN_WIDTH{1'b0}})) begin
      requant = {IN_WIDTH{1'b0}};
    end else if (s > SAT_MAX) begin
      requant = SAT_MAX;
    end else begin
      requant = s;
    end
  endfunction

  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                row_q, row_d;
  logic signed [IN_WIDTH-1:0]   hold_q, hold_d;
  logic [IN_WIDTH-1:0]          data_out_q, data_out_d;
  logic                         valid_out_q, valid_out_d;
  logic                         frame_done_q, frame_done_d;
  logic signed [IN_WIDTH-1:0]   rowbuf_q [IN_W/2];

  logic signed [IN_WIDTH-1:0]   data_in_s;
  logic signed [IN_WIDTH-1:0]   pmax_s;
  logic signed [IN_WIDTH-1:0]   win_max_s;
  logic [IN_WIDTH-1:0]          result_s;
  logic [CW-2:0]                bidx_s;
  logic                         last_col_s;
  logic                         last_row_s;
  logic                         buf_we_s;

  assign data_in_s  = $signed(data_in);
  assign bidx_s     = col_q[CW-1:1];
  assign last_col_s = (col_q == COL_LAST);
  assign last_row_s = (row_q == ROW_LAST);
  assign pmax_s     = smax(hold_q, data_in_s);
  assign win_max_s  = smax(rowbuf_q[bidx_s], pmax_s);

`ifdef MAXPOOL_REQUANT_EN
  assign result_s = requant(win_max_s);
`else
  assign result_s = win_max_s;
`endif

  // Raster position tracking, horizontal pairing and window completion.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    buf_we_s     = 1'b0;
    if (valid_in) begin
      if (col_q[0] == 1'b0) begin
        hold_d = data_in_s;
      end else if (row_q[0] == 1'b0) begin
        buf_we_s = 1'b1;
      end else begin
        data_out_d   = result_s;
        valid_out_d  = 1'b1;
        frame_done_d = last_col_s && last_row_s;
      end
      if (last_col_s) begin
        col_d = {CW{1'b0}};
        if (last_row_s) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + ROW_ONE;
        end
      end else begin
        col_d = col_q + COL_ONE;
      end
    end else begin
      hold_d = hold_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      hold_q       <= {IN_WIDTH{1'b0}};
      data_out_q   <= {IN_WIDTH{1'b0}};
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Partial-max buffer needs no reset: every entry is written on an even row before it is read.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      rowbuf_q[bidx_s] <= pmax_s;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Randomized self-checking bench for maxpool2x2_stream against a window-max reference model.
// Expectations follow MAXPOOL_REQUANT_EN when it is defined for the build.
module tb_maxpool2x2_stream;

  localparam int W    = 24;
  localparam int H    = 24;
  localparam int NPX  = W * H;
  localparam int NOUT = (W / 2) * (H / 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int fd_alone = 0;

  logic signed [31:0] px [2*NPX];
  logic signed [31:0] out_val_q [$];
  int                 out_cyc_q [$];
  bit                 out_fd_q  [$];
  int                 acc_cyc_q [$];

  always #5 clk = ~clk;

  maxpool2x2_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .frame_done(frame_done)
  );

  // Monitor on the falling edge: record outputs and which cycle accepts each input.
  always @(negedge clk) begin
    if (valid_out) begin
      out_val_q.push_back($signed(data_out));
      out_cyc_q.push_back(cyc);
      out_fd_q.push_back(frame_done);
    end
    if (frame_done && !valid_out) fd_alone++;
    if (valid_in && rst_n) acc_cyc_q.push_back(cyc);
    cyc++;
  end

  function automatic logic signed [31:0] rq(input logic signed [31:0] m);
`ifdef MAXPOOL_REQUANT_EN
    if (m < 0) return 32'sd0;
    if (m / 256 > 255) return 32'sd255;
    return m / 256;
`else
    return m;
`endif
  endfunction

  // Expected pooled value for output k (frames are concatenated in px).
  function automatic logic signed [31:0] model_out(input int k);
    int f, r, c;
    logic signed [31:0] m;
    f = k / NOUT;
    r = (k % NOUT) / (W / 2);
    c = k % (W / 2);
    m = px[f*NPX + (2*r)*W + 2*c];
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (px[f*NPX + (2*r+dr)*W + 2*c+dc] > m) m = px[f*NPX + (2*r+dr)*W + 2*c+dc];
    return rq(m);
  endfunction

  function automatic int br_index(input int k);
    int f, r, c;
    f = k / NOUT;
    r = (k % NOUT) / (W / 2);
    c = k % (W / 2);
    return f*NPX + (2*r+1)*W + 2*c+1;
  endfunction

  task automatic clear_mon();
    out_val_q.delete();
    out_cyc_q.delete();
    out_fd_q.delete();
    acc_cyc_q.delete();
    fd_alone = 0;
  endtask

  task automatic fill_ramp(input int f);
    for (int i = 0; i < NPX; i++) px[f*NPX + i] = i;
  endtask

  task automatic drive_px(input logic signed [31:0] v, input int gap_pct);
    while ($urandom_range(0, 99) < gap_pct) begin
      @(posedge clk); #1;
    end
    valid_in = 1'b1;
    data_in  = v;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drive_range(input int first, input int count, input int gap_pct);
    for (int i = first; i < first + count; i++) drive_px(px[i], gap_pct);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL reset_data_out got=%0h exp=0", data_out); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out got=%b exp=0", valid_out); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    clear_mon();
    fill_ramp(0);
    drive_range(0, NPX, 0);
    idle(4);
    n_cmp++; if (out_val_q.size() !== NOUT) begin n_err++; $display("FAIL ramp_count got=%0d exp=%0d", out_val_q.size(), NOUT); end
    n_cmp++; if (fd_alone !== 0) begin n_err++; $display("FAIL ramp_fd_alone got=%0d exp=0", fd_alone); end
    if (out_val_q.size() > 0) begin
      n_cmp++; if (out_val_q[0] !== rq(32'sd25)) begin n_err++; $display("FAIL ramp_first got=%0d exp=%0d", out_val_q[0], rq(32'sd25)); end
      n_cmp++; if (out_val_q[out_val_q.size()-1] !== rq(32'sd575)) begin n_err++; $display("FAIL ramp_last got=%0d exp=%0d", out_val_q[out_val_q.size()-1], rq(32'sd575)); end
    end
    for (int k = 0; k < out_val_q.size() && k < NOUT; k++) begin
      n_cmp++; if (out_val_q[k] !== model_out(k)) begin n_err++; $display("FAIL ramp_val[%0d] got=%0d exp=%0d", k, out_val_q[k], model_out(k)); end
      n_cmp++; if (out_fd_q[k] !== (k == NOUT-1)) begin n_err++; $display("FAIL ramp_fd[%0d] got=%b exp=%b", k, out_fd_q[k], (k == NOUT-1)); end
      n_cmp++; if (out_cyc_q[k] !== acc_cyc_q[br_index(k)] + 1) begin n_err++; $display("FAIL ramp_lat[%0d] got=%0d exp=%0d", k, out_cyc_q[k], acc_cyc_q[br_index(k)] + 1); end
    end
  endtask

  task automatic test_negative();
    logic signed [31:0] exp0;
    clear_mon();
    for (int i = 0; i < NPX; i++) px[i] = $signed($urandom_range(0, 2000)) - 32'sd1000;
    px[0] = -32'sd7; px[1] = -32'sd3; px[W] = -32'sd9; px[W+1] = -32'sd5;
`ifdef MAXPOOL_REQUANT_EN
    exp0 = 32'sd0;
`else
    exp0 = -32'sd3;
`endif
    drive_range(0, NPX, 0);
    idle(4);
    n_cmp++; if (out_val_q.size() !== NOUT) begin n_err++; $display("FAIL neg_count got=%0d exp=%0d", out_val_q.size(), NOUT); end
    if (out_val_q.size() > 0) begin
      n_cmp++; if (out_val_q[0] !== exp0) begin n_err++; $display("FAIL neg_first got=%0d exp=%0d", out_val_q[0], exp0); end
    end
    for (int k = 0; k < out_val_q.size() && k < NOUT; k++) begin
      n_cmp++; if (out_val_q[k] !== model_out(k)) begin n_err++; $display("FAIL neg_val[%0d] got=%0d exp=%0d", k, out_val_q[k], model_out(k)); end
    end
  endtask

  task automatic test_random_gaps();
    clear_mon();
    fill_ramp(0);
    drive_range(0, NPX, 50);
    idle(4);
    n_cmp++; if (out_val_q.size() !== NOUT) begin n_err++; $display("FAIL gap_count got=%0d exp=%0d", out_val_q.size(), NOUT); end
    for (int k = 0; k < out_val_q.size() && k < NOUT; k++) begin
      n_cmp++; if (out_val_q[k] !== model_out(k)) begin n_err++; $display("FAIL gap_val[%0d] got=%0d exp=%0d", k, out_val_q[k], model_out(k)); end
      n_cmp++; if (out_cyc_q[k] !== acc_cyc_q[br_index(k)] + 1) begin n_err++; $display("FAIL gap_lat[%0d] got=%0d exp=%0d", k, out_cyc_q[k], acc_cyc_q[br_index(k)] + 1); end
    end
  endtask

  task automatic test_back_to_back();
    int nfd;
    clear_mon();
    for (int i = 0; i < 2*NPX; i++) px[i] = $signed($urandom);
    drive_range(0, 2*NPX, 0);
    idle(4);
    nfd = 0;
    foreach (out_fd_q[k]) if (out_fd_q[k]) nfd++;
    n_cmp++; if (out_val_q.size() !== 2*NOUT) begin n_err++; $display("FAIL b2b_count got=%0d exp=%0d", out_val_q.size(), 2*NOUT); end
    n_cmp++; if (nfd !== 2) begin n_err++; $display("FAIL b2b_fd_pulses got=%0d exp=2", nfd); end
    for (int k = 0; k < out_val_q.size() && k < 2*NOUT; k++) begin
      n_cmp++; if (out_val_q[k] !== model_out(k)) begin n_err++; $display("FAIL b2b_val[%0d] got=%0d exp=%0d", k, out_val_q[k], model_out(k)); end
      n_cmp++; if (out_fd_q[k] !== ((k % NOUT) == NOUT-1)) begin n_err++; $display("FAIL b2b_fd[%0d] got=%b", k, out_fd_q[k]); end
    end
  endtask

  task automatic test_saturate();
    logic signed [31:0] exps;
    clear_mon();
    for (int i = 0; i < NPX; i++) px[i] = 32'sh7FFF_FFFF;
`ifdef MAXPOOL_REQUANT_EN
    exps = 32'sd255;
`else
    exps = 32'sh7FFF_FFFF;
`endif
    drive_range(0, NPX, 0);
    idle(4);
    n_cmp++; if (out_val_q.size() !== NOUT) begin n_err++; $display("FAIL sat_count got=%0d exp=%0d", out_val_q.size(), NOUT); end
    for (int k = 0; k < out_val_q.size() && k < NOUT; k++) begin
      n_cmp++; if (out_val_q[k] !== exps) begin n_err++; $display("FAIL sat_val[%0d] got=%0d exp=%0d", k, out_val_q[k], exps); end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < NPX; i++) px[i] = $signed($urandom);
    drive_range(0, 300, 0);
    rst_n = 1'b0;
    #2;
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL midrst_data_out got=%0h exp=0", data_out); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_valid_out got=%b exp=0", valid_out); end
    idle(2);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    fill_ramp(0);
    drive_range(0, NPX, 0);
    idle(4);
    n_cmp++; if (out_val_q.size() !== NOUT) begin n_err++; $display("FAIL midrst_count got=%0d exp=%0d", out_val_q.size(), NOUT); end
    for (int k = 0; k < out_val_q.size() && k < NOUT; k++) begin
      n_cmp++; if (out_val_q[k] !== model_out(k)) begin n_err++; $display("FAIL midrst_val[%0d] got=%0d exp=%0d", k, out_val_q[k], model_out(k)); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_random_gaps();
    test_back_to_back();
    test_saturate();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of `conv_accelerator`. It consumes the raster-ordered 24×24 signed feature map (`result_ch0`/`result_valid`) and emits a 12×12 pooled map in raster order. Each 2×2 window is reduced on the fly, using a half-row buffer of partial maxima. An optional requantizer narrows results to unsigned activations for the next convolution layer.

## Interface
- `IN_W`, 24, input map width in pixels; must be even.
- `IN_H`, 24, input map height in pixels; must be even.
- `IN_WIDTH`, 32, signed input sample width.
- `SHIFT`, 8, arithmetic right shift applied when requantization is compiled in.
- `SAT_WIDTH`, 8, unsigned saturation width when requantization is compiled in.
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_in`  in  1  input sample strobe; `data_in` is sampled on each cycle it is high.
- `data_in`  in  IN_WIDTH  signed conv result, raster order.
- `data_out`  out  IN_WIDTH  pooled value, signed; zero-extended unsigned when requantized.
- `valid_out`  out  1  one-cycle strobe per pooled value.
- `frame_done`  out  1  high together with `valid_out` for the last pooled value of a frame.

## Operation
- Counters:
  - `col` runs 0..IN_W-1 and `row` runs 0..IN_H-1. Both advance only on cycles where `valid_in` is high.
  - `col` wraps to 0 and increments `row`. `row` wraps to 0 after IN_H-1, and the next frame starts with no idle cycles required.
- Horizontal pair:
  - At even `col`, the sample is registered into `hold`.
  - At odd `col`, `pmax = max(hold, data_in)`, a signed compare.
- Even `row`, odd `col`: `buf[col>>1] <= pmax`. The buffer has IN_W/2 entries of IN_WIDTH bits.
- Odd `row`, odd `col`: `max(buf[col>>1], pmax)` goes to the output register and `valid_out` is raised on the next cycle. No output is produced at any other position.
- Ties select either operand; the result is identical.
- Gaps in `valid_in`:
  - All state holds while `valid_in` is low.
  - Output order and values are independent of the gap pattern.
- Reset mid-frame: counters, `hold` and the outputs clear. Buffer contents are don't-care, because they are overwritten before they are read.
- Output count per frame is exactly (IN_W/2)·(IN_H/2), i.e. 144 with the defaults.

## Timing
- Reset values: `data_out` = 0, `valid_out` = 0, `frame_done` = 0, `col` = 0, `row` = 0, `hold` = 0.
- Latency: `valid_out` rises exactly 1 cycle after the cycle that accepts the bottom-right sample of a window.
- Throughput: one input per cycle sustained, with no backpressure. The downstream stage must accept every `valid_out` pulse.
- `valid_out` and `frame_done` are single-cycle pulses. `data_out` holds its value until the next `valid_out`.
- `frame_done` coincides with the output for the window at row IN_H-1, col IN_W-1.
- If `valid_in` is high in the cycle right after a frame's last sample, that sample is frame N+1 pixel (0,0). `frame_done` for frame N still asserts in that cycle.

## Configuration
- `MAXPOOL_REQUANT_EN` defined:
  - The output register loads `m >>> SHIFT`, where `m` is the window max.
  - The value is clamped to [0, 2^SAT_WIDTH-1] and zero-extended to IN_WIDTH.
  - Latency is unchanged; the requantizer is combinational before the output register.
- `MAXPOOL_REQUANT_EN` undefined: `data_out` is the raw signed window max, full IN_WIDTH.

## Test plan
- Ramp frame, `data_in` = row·24+col, continuous valid, macro off:
  - 144 outputs, out(r,c) = (2r+1)·24+2c+1.
  - First output 25, last 575. `frame_done` only on the last output.
- Negative window, samples {-7,-3,-9,-5} in the first window, macro off:
  - Output -3, which confirms the signed compare.
  - Same window with macro on: output 0.
- Ramp frame with a pseudo-random 50% `valid_in` duty:
  - Values identical to the continuous run.
  - Each `valid_out` occurs 1 cycle after its 4th window sample.
- Two back-to-back frames with no idle cycle:
  - 288 outputs and two `frame_done` pulses.
  - Frame 2 values are correct, with no carry-over from frame 1.
- Macro on, SHIFT=8, SAT_WIDTH=8:
  - Ramp frame: out(0,0)=0, out(11,11)=2.
  - All samples 0x7FFF_FFFF: every output is 255.
- `rst_n` pulsed low after 300 samples, then a full ramp frame:
  - Outputs drop to 0 during reset.
  - Exactly 144 correct outputs follow and none are stale.
